immediate_encoder: RTL and testbench

Inverse of the immediate generation unit: packs a 32-bit immediate into the instruction-word bit positions dictated by the instruction type, merging it with a caller-supplied template of the non-immediate fields.

- Two-stage pipelined encoder with a valid/ready handshake on both sides.
- Checks that the immediate is representable in the selected format and flags misalignment.
- Keeps a saturating count of rejected encodings.
- Users: the self-test / fault-injection instruction builder and the approximate-code patcher, both of which rewrite instruction words in memory.

---
 rtl/immediate_encoder_pkg.sv | 32 +++
 rtl/immediate_packer.sv | 56 +++++
 rtl/immediate_encoder.sv | 126 ++++++++++++
 tb/tb_immediate_encoder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_encoder_pkg.sv
// Shared defines for the immediate encoder: instruction-type codes, error-bit
// indices, the stage-1 payload and a representability helper.
package immediate_encoder_pkg;

    typedef enum logic [2:0] {
        ITYPE_R = 3'd0,
        ITYPE_I = 3'd1,
        ITYPE_S = 3'd2,
        ITYPE_B = 3'd3,
        ITYPE_U = 3'd4,
        ITYPE_J = 3'd5
    } itype_e;

    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_TYPE  = 2;
    localparam int ERR_WIDTH = 3;

    typedef struct packed {
        logic [31:0] immediate;
        logic [2:0]  instruction_type;
        logic [24:0] template;
    } s1_beat_t;

    // True when value[31:lsb] is a pure sign extension (all zeros or all ones).
    function automatic logic upper_uniform(input logic [31:0] value, input int unsigned lsb);
        logic [31:0] shifted;
        shifted = $unsigned($signed(value) >>> lsb);
        return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/immediate_packer.sv
// Combinational immediate packing plus range/alignment/type checking.
// Bit positions below are instruction bit numbers minus 7 (template covers [31:7]).
module immediate_packer
    import immediate_encoder_pkg::*;
(
    input  logic [31:0]          immediate,
    input  logic [2:0]           instruction_type,
    input  logic [24:0]          template,
    output logic [24:0]          instruction,
    output logic [ERR_WIDTH-1:0] errors
);

    // Overlay the immediate fields on the template and flag unencodable values.
    always_comb begin
        instruction = template;
        errors      = {ERR_WIDTH{1'b0}};
        case (instruction_type)
            ITYPE_R: begin
                instruction = template;
            end
            ITYPE_I: begin
                instruction[24:13] = immediate[11:0];
                errors[ERR_RANGE]  = !upper_uniform(immediate, 32'd11);
            end
            ITYPE_S: begin
                instruction[24:18] = immediate[11:5];
                instruction[4:0]   = immediate[4:0];
                errors[ERR_RANGE]  = !upper_uniform(immediate, 32'd11);
            end
            ITYPE_B: begin
                instruction[24]    = immediate[12];
                instruction[23:18] = immediate[10:5];
                instruction[4:1]   = immediate[4:1];
                instruction[0]     = immediate[11];
                errors[ERR_RANGE]  = !upper_uniform(immediate, 32'd12);
                errors[ERR_ALIGN]  = immediate[0];
            end
            ITYPE_U: begin
                instruction[24:5]  = immediate[31:12];
                errors[ERR_RANGE]  = (immediate[11:0] != 12'h000);
            end
            ITYPE_J: begin
                instruction[24]    = immediate[20];
                instruction[23:14] = immediate[10:1];
                instruction[13]    = immediate[11];
                instruction[12:5]  = immediate[19:12];
                errors[ERR_RANGE]  = !upper_uniform(immediate, 32'd20);
                errors[ERR_ALIGN]  = immediate[0];
            end
            default: begin
                errors[ERR_TYPE] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immediate_encoder.sv
// Two-stage pipelined immediate encoder: S1 captures the request, S2 holds the
// packed word and error flags; a saturating counter tallies errored deliveries.
module immediate_encoder
    import immediate_encoder_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            immediate,
    input  logic [2:0]             instruction_type,
    input  logic [24:0]            template,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [24:0]            instruction,
    output logic                   range_error,
    output logic                   align_error,
    output logic                   type_error,
    input  logic                   clear_count,
    output logic [COUNT_WIDTH-1:0] error_count
);

    logic                   s1_valid_q, s1_valid_d;
    s1_beat_t               s1_beat_q, s1_beat_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [24:0]            s2_instr_q, s2_instr_d;
    logic [ERR_WIDTH-1:0]   s2_errors_q, s2_errors_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [24:0]            packer_instr;
    logic [ERR_WIDTH-1:0]   packer_errors;
    logic                   out_fire;
    logic                   s2_open;
    logic                   s1_advance;
    logic                   in_fire;

    immediate_packer u_packer (
        .immediate        (s1_beat_q.immediate),
        .instruction_type (s1_beat_q.instruction_type),
        .template         (s1_beat_q.template),
        .instruction      (packer_instr),
        .errors           (packer_errors)
    );

    // Handshake: a stage opens when empty or when its content leaves this cycle.
    always_comb begin
        out_fire   = s2_valid_q && out_ready;
        s2_open    = !s2_valid_q || out_fire;
        s1_advance = s1_valid_q && s2_open;
        in_ready   = !s1_valid_q || s1_advance;
        in_fire    = in_valid && in_ready;
    end

    // Next-state for both pipeline stages and the error counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_beat_d   = s1_beat_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_errors_d = s2_errors_q;
        count_d     = count_q;

        if (in_fire) begin
            s1_valid_d                 = 1'b1;
            s1_beat_d.immediate        = immediate;
            s1_beat_d.instruction_type = instruction_type;
            s1_beat_d.template         = template;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_open) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (s1_advance) begin
            s2_instr_d  = packer_instr;
            s2_errors_d = packer_errors;
        end else begin
            s2_instr_d  = s2_instr_q;
            s2_errors_d = s2_errors_q;
        end

        // Clear takes priority over a coincident errored delivery.
        if (clear_count) begin
            count_d = {COUNT_WIDTH{1'b0}};
        end else if (out_fire && (|s2_errors_q) && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous reset discarding any in-flight beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_beat_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 25'd0;
            s2_errors_q <= {ERR_WIDTH{1'b0}};
            count_q     <= {COUNT_WIDTH{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_beat_q   <= s1_beat_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_errors_q <= s2_errors_d;
            count_q     <= count_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign instruction = s2_instr_q;
    assign range_error = s2_errors_q[ERR_RANGE];
    assign align_error = s2_errors_q[ERR_ALIGN];
    assign type_error  = s2_errors_q[ERR_TYPE];
    assign error_count = count_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Scoreboard bench for immediate_encoder: stimulus pushes model results into a
// queue, a negedge monitor pops and compares each delivered word.
module tb_immediate_encoder;
    import immediate_encoder_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   immediate;
    logic [2:0]    instruction_type;
    logic [24:0]   template;
    logic          out_valid;
    logic          out_ready;
    logic [24:0]   instruction;
    logic          range_error;
    logic          align_error;
    logic          type_error;
    logic          clear_count;
    logic [CW-1:0] error_count;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  t;
        logic [24:0] instr;
        logic        rng;
        logic        aln;
        logic        typ;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_count = 0;
    logic saw_full = 1'b0;
    logic rand_done = 1'b0;

    always #5 clk = ~clk;

    immediate_encoder #(.COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .immediate        (immediate),
        .instruction_type (instruction_type),
        .template         (template),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .instruction      (instruction),
        .range_error      (range_error),
        .align_error      (align_error),
        .type_error       (type_error),
        .clear_count      (clear_count),
        .error_count      (error_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value ranges and bit-field masks computed directly from the format rules.
    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] t, input logic [24:0] tmpl);
        exp_t        e;
        longint      v;
        logic [31:0] word;
        logic [31:0] field;
        logic [31:0] mask;
        v     = longint'($signed(imm));
        word  = {tmpl, 7'b0};
        field = 32'd0;
        mask  = 32'd0;
        e.imm = imm; e.t = t; e.rng = 1'b0; e.aln = 1'b0; e.typ = 1'b0;
        case (t)
            ITYPE_R: mask = 32'd0;
            ITYPE_I: begin
                mask  = 32'hFFF0_0000;
                field = imm << 20;
                e.rng = (v < -2048) || (v > 2047);
            end
            ITYPE_S: begin
                mask  = 32'hFE00_0F80;
                field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e.rng = (v < -2048) || (v > 2047);
            end
            ITYPE_B: begin
                mask  = 32'hFE00_0F80;
                field = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7);
                e.rng = (v < -4096) || (v > 4095);
                e.aln = imm[0];
            end
            ITYPE_U: begin
                mask  = 32'hFFFF_F000;
                field = imm & mask;
                e.rng = (imm % 32'd4096) != 32'd0;
            end
            ITYPE_J: begin
                mask  = 32'hFFFF_F000;
                field = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'd1) << 20) | (imm & 32'h000F_F000);
                e.rng = (v < -1048576) || (v > 1048575);
                e.aln = imm[0];
            end
            default: e.typ = 1'b1;
        endcase
        word    = (word & ~mask) | (field & mask);
        e.instr = word[31:7];
        return e;
    endfunction

    // Core immediate-generation view of an instruction word, used for round-trip checks.
    function automatic logic [31:0] decode(input logic [24:0] ins, input logic [2:0] t);
        logic [31:0] w;
        w = {ins, 7'b0};
        case (t)
            ITYPE_I: return {{20{w[31]}}, w[31:20]};
            ITYPE_S: return {{20{w[31]}}, w[31:25], w[11:7]};
            ITYPE_B: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            ITYPE_U: return {w[31:12], 12'b0};
            ITYPE_J: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        logic [11:0] s12;
        logic [20:0] s21;
        r   = $urandom;
        s12 = r[11:0];
        s21 = r[20:0];
        case ($urandom_range(0, 4))
            0: return r;
            1: return {{20{s12[11]}}, s12};
            2: return {{11{s21[20]}}, s21[20:1], 1'b0};
            3: return {{19{r[12]}}, r[12:1], 1'b0};
            default: return {r[31:12], 12'h000};
        endcase
    endfunction

    task automatic send(input logic [31:0] imm, input logic [2:0] t, input logic [24:0] tmpl);
        int guard = 0;
        in_valid = 1'b1; immediate = imm; instruction_type = t; template = tmpl;
        #1;
        while (!in_ready && guard < 100) begin
            saw_full = 1'b1;
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0");
        end else begin
            exp_q.push_back(model(imm, t, tmpl));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int guard = 0;
        #1;
        while (!out_valid && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: counter check, stall stability, then scoreboard pop on each handshake.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        hs;
        logic        err;
        logic        stalled_prev;
        logic [27:0] prev_out;
        #2;
        if (reset === 1'b0) begin
            check("error_count", error_count, model_count[CW-1:0]);
        end
        if (stalled_prev === 1'b1 && reset === 1'b0) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_hold", {instruction, range_error, align_error, type_error}, prev_out);
        end
        stalled_prev = (reset === 1'b0) && out_valid && !out_ready;
        prev_out     = {instruction, range_error, align_error, type_error};
        hs  = (reset === 1'b0) && out_valid && out_ready;
        err = 1'b0;
        if (reset !== 1'b0) begin
            model_count = 0;
        end else begin
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: instruction %h with empty scoreboard", instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("instruction", instruction, e.instr);
                    check("range_error", range_error, e.rng);
                    check("align_error", align_error, e.aln);
                    check("type_error", type_error, e.typ);
                    err = e.rng | e.aln | e.typ;
                    if (!err && e.t != ITYPE_R) begin
                        check("round_trip", decode(instruction, e.t), e.imm);
                    end
                end
            end
            if (clear_count) begin
                model_count = 0;
            end else if (hs && err && model_count < (1 << CW) - 1) begin
                model_count++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; immediate = 32'd0; instruction_type = 3'd0;
        template = 25'd0; out_ready = 1'b1; clear_count = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_instruction", instruction, 25'd0);
        check("reset_flags", {range_error, align_error, type_error}, 3'b000);
        check("reset_error_count", error_count, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #3;
        check("in_ready_after_reset", in_ready, 1'b1);

        // I-type encode with latency check
        @(negedge clk);
        send(32'hFFFF_F800, ITYPE_I, 25'd0);
        #3 check("i_latency_n1", out_valid, 1'b0);
        @(negedge clk); #3;
        check("i_latency_n2", out_valid, 1'b1);
        check("i_field", instruction[24:13], 12'h800);
        check("i_flags", {range_error, align_error, type_error}, 3'b000);
        drain();

        // Misaligned B-type
        send(32'h0000_0FFF, ITYPE_B, 25'($urandom));
        wait_out(); #2;
        check("b_align", align_error, 1'b1);
        check("b_range", range_error, 1'b0);
        drain();
        check("b_count", error_count, 4'd1);

        // U-type range check
        send(32'h1234_5001, ITYPE_U, 25'd0);
        send(32'h1234_5000, ITYPE_U, 25'd0);
        wait_out(); #2;
        check("u_range_bad", range_error, 1'b1);
        @(negedge clk); #3;
        check("u_good_valid", out_valid, 1'b1);
        check("u_good_field", instruction[24:5], 20'h12345);
        check("u_good_range", range_error, 1'b0);
        drain();

        // Backpressure mid-stream
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_imm(), 3'($urandom_range(0, 5)), 25'($urandom));
            end
            begin
                @(negedge clk); @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", saw_full, 1'b1);

        // Saturation and clear
        for (int i = 0; i < 17; i++) send(32'($urandom), 3'd7, 25'($urandom));
        drain();
        check("sat_all_ones", error_count, 4'hF);
        send(32'd0, 3'd6, 25'd0);
        drain();
        check("sat_hold", error_count, 4'hF);
        send(32'd0, 3'd7, 25'd0);
        wait_out();
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        #3 check("clear_wins", error_count, 4'd0);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'd5, 3'd7, 25'h1);
        send(32'd6, 3'd7, 25'h2);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk); #3;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_count", error_count, 4'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3 check("rst_no_ghost", out_valid, 1'b0);

        // Randomized traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    send(rand_imm(), 3'($urandom_range(0, 7)), 25'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                for (int k = 0; k < 5000 && !rand_done; k++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
